// File: rtl/dp_sequencer.sv
// ---------------------------------------------------------------------------
// dp_sequencer
//
// Control unit for a 4-bit register datapath made of three loadable
// registers R0..R2, an accumulator A, a B-source mux and an ALU.
//
// A START request clears the datapath and then loads R0..R2 from the
// external M inputs. After that, the block executes one instruction for each
// accepted valid/ready transfer:
//   A <- ALU(B, A)        (EXEC cycle)
//   R[DST] <- A           (WB cycle, skipped when DST = 3)
//
// Optional feature macro: DP_SEQUENCER_CNT_EN
//   defined   : INSTR_CNT is an 8-bit wrapping count of retired instructions
//   undefined : no counter logic is built and INSTR_CNT is tied to 0
//
// Ports
//   CLK          in   1  clock; all state changes on the rising edge
//   CLR          in   1  synchronous active-high reset
//   START        in   1  level; starts the clear+load sequence from IDLE/WAIT
//   INSTR_VALID  in   1  an instruction is present on INSTR
//   INSTR        in   7  [6:4] ALU op, [3:2] B-source select, [1:0] DST
//   INSTR_READY  out  1  an instruction can be accepted this cycle
//   DP_CLR       out  1  datapath synchronous clear
//   W            out  3  per-register input select (0 = M input, 1 = A)
//   CE           out  4  clock enables: [2:0] = R2..R0, [3] = A
//   SEL          out  2  B-source select (3 = constant 0)
//   S            out  3  ALU operation code
//   DONE         out  1  one-cycle pulse when an instruction retires
//   BUSY         out  1  high in every state except IDLE and WAIT
//   INSTR_CNT    out  8  retired-instruction count (0 without the macro)
// ---------------------------------------------------------------------------
module dp_sequencer (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       START,
    input  logic       INSTR_VALID,
    input  logic [6:0] INSTR,
    output logic       INSTR_READY,
    output logic       DP_CLR,
    output logic [2:0] W,
    output logic [3:0] CE,
    output logic [1:0] SEL,
    output logic [2:0] S,
    output logic       DONE,
    output logic       BUSY,
    output logic [7:0] INSTR_CNT
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EXEC  = 3'd4,
        ST_WB    = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [6:0] r_ir;
    logic       r_done;
    logic       w_handshake;
    logic [1:0] w_dst;

    // START has priority over a pending instruction: while START is high in
    // WAIT the sequencer withholds READY, so no transfer can complete.
    assign INSTR_READY = (r_state == ST_WAIT) && !START;
    assign w_handshake = INSTR_READY && INSTR_VALID;
    assign w_dst       = r_ir[1:0];

    // The datapath clear follows CLR combinationally so the registers it
    // controls are reset on the same edge as the sequencer itself.
    assign DP_CLR = CLR || (r_state == ST_CLEAR);
    assign DONE   = r_done;
    assign BUSY   = (r_state != ST_IDLE) && (r_state != ST_WAIT);

    // -----------------------------------------------------------------------
    // State, instruction register and DONE pulse
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others regardless of
    // statement order.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= ST_IDLE;
            r_ir    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_handshake) begin
                r_ir <= INSTR;
            end
            // DONE marks the cycle right after WB, when R[DST] is settled.
            r_done <= (r_state == ST_WB);
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and Moore control-word decode
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case
    // statement; a path that left one unassigned would infer a latch.
    always_comb begin
        w_next_state = r_state;
        W            = 3'b000;
        CE           = 4'b0000;
        SEL          = 2'b00;
        S            = 3'b000;

        unique case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_next_state = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                w_next_state = ST_LOAD;
            end

            ST_LOAD: begin
                // W = 000 routes M0..M2 into R0..R2.
                CE           = 4'b0111;
                w_next_state = ST_WAIT;
            end

            ST_WAIT: begin
                if (START) begin
                    w_next_state = ST_CLEAR;
                end else if (INSTR_VALID) begin
                    w_next_state = ST_EXEC;
                end
            end

            ST_EXEC: begin
                SEL          = r_ir[3:2];
                S            = r_ir[6:4];
                CE           = 4'b1000;
                w_next_state = ST_WB;
            end

            ST_WB: begin
                SEL = r_ir[3:2];
                S   = r_ir[6:4];
                // One-hot write of the destination register from A; DST = 3
                // leaves every enable low so only A was updated.
                case (w_dst)
                    2'd0: begin W = 3'b001; CE = 4'b0001; end
                    2'd1: begin W = 3'b010; CE = 4'b0010; end
                    2'd2: begin W = 3'b100; CE = 4'b0100; end
                    default: begin W = 3'b000; CE = 4'b0000; end
                endcase
                w_next_state = ST_WAIT;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Retired-instruction counter
    // -----------------------------------------------------------------------
`ifdef DP_SEQUENCER_CNT_EN
    logic [7:0] r_instr_cnt;

    // Counts in the WB cycle so the new value is visible alongside DONE.
    // Entering CLEAR (from IDLE or WAIT) restarts the count; an instruction
    // abandoned by CLR before WB is never counted.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_instr_cnt <= '0;
        end else if (w_next_state == ST_CLEAR) begin
            r_instr_cnt <= '0;
        end else if (r_state == ST_WB) begin
            r_instr_cnt <= r_instr_cnt + 8'd1;
        end
    end

    assign INSTR_CNT = r_instr_cnt;
`else
    assign INSTR_CNT = 8'd0;
`endif

endmodule
